jpeg_bitstream_packer: RTL and testbench
========================================

// Module: jpeg_bitstream_packer
// PURPOSE
//  Sits directly downstream of the Huffman encoder controller. Takes its variable-length
//  code chunks (jpeg_out / jpeg_data_bits) and packs them MSB-first into a byte stream.
//  Applies JPEG 0xFF->0xFF,0x00 byte stuffing and pads the final partial byte with 1s.
//  Output bytes are buffered in a FIFO with a valid/ready interface towards the file writer.
// PARAMETERS
//  FIFO_DEPTH  16  output byte FIFO entries; power of 2, >=4
//  LVL_W       5   width of fifo_level = clog2(FIFO_DEPTH)+1
// PORTS
//  clock       in   1      rising-edge clock
//  reset_n     in   1      asynchronous active-low reset
//  bits_in     in   8      code chunk, right-aligned; first bit sent = bits_in[bits_len-1]
//  bits_len    in   4      valid bits in bits_in, 0..8; values 9..15 treated as 8
//  bits_valid  in   1      chunk present
//  bits_ready  out  1      packer accepts chunk this cycle
//  flush       in   1      end-of-scan request, single-cycle pulse
//  byte_out    out  8      output byte (FIFO head)
//  byte_valid  out  1      byte_out valid
//  byte_ready  in   1      consumer takes byte_out
//  flush_done  out  1      1-cycle pulse: flush finished, all output bytes are in the FIFO
//  fifo_level  out  LVL_W  bytes currently held in the FIFO
// BEHAVIOUR
//  - Reset (async): acc=0, cnt=0, state=RUN, FIFO empty.
//    byte_out=0, byte_valid=0, flush_done=0, fifo_level=0.
//    bits_ready=0 while reset_n is low.
//  - Accumulator acc[15:0], fill count cnt 0..15; valid bits are left-justified (acc[15] is the oldest bit).
//  - free = FIFO_DEPTH - fifo_level.
//  - Extract: in RUN/FLUSH, if cnt>=8 and free>=2:
//    push acc[15:8], shift acc left 8, cnt-=8. Pushed byte==0xFF -> next state STUFF.
//  - bits_ready = (state==RUN) && !flush_pending && free>=2 && (cnt<=7 || extract this cycle).
//  - Accept (bits_valid&&bits_ready): append len bits after the post-extract count.
//    Max fill is 15, so no overflow. len==0 is accepted and is a no-op.
//  - Throughput: 1 chunk/cycle sustained. Extract and accept in the same cycle is legal.
//  - States:
//    - RUN
//    - STUFF: push 0x00 when free>=1, then return to the state it came from. No accept.
//    - FLUSH
//    - PAD
//    - EOI1, EOI2 (only when the macro is defined)
//    - DONE
//  - flush is sampled in RUN. If it coincides with an accepted chunk, the chunk is taken first.
//    A flush arriving while not in RUN is latched (flush_pending) and served on return to RUN.
//  - FLUSH: keep extracting until cnt<8.
//    Then, if cnt>0 -> PAD, else -> EOI1 (if enabled) or DONE.
//  - PAD: push {remaining bits, 1s to 8 bits} when free>=2; cnt=0.
//    If the padded byte is 0xFF -> STUFF, then continue.
//  - DONE: flush_done=1 for one cycle; acc/cnt cleared; -> RUN.
//  - FIFO:
//    - 1 write/cycle max (extract, stuff, pad or marker).
//    - A read happens when byte_valid&&byte_ready.
//    - Simultaneous read+write: level unchanged.
//    - Write pointer and read pointer wrap modulo FIFO_DEPTH.
//    - Never overflows: every write path is gated by free, so a write never occurs when full.
//    - byte_valid = FIFO not empty; byte_out is the registered head. First-word latency is 1 cycle after push.
//  - Output order equals bit order of input. No byte is ever dropped or duplicated under backpressure.
//  - reset_n low mid-stream: all partial bits and FIFO content are discarded immediately.
// CONFIGURATION
//  - JPEG_EOI_EN defined: after FLUSH/PAD, states EOI1/EOI2 push 0xFF then 0xD9. These are not stuffed.
//    Each needs free>=1. flush_done is asserted after 0xD9 is in the FIFO.
//  - JPEG_EOI_EN undefined: EOI1/EOI2 do not exist; FLUSH/PAD go straight to DONE.
// TESTING
//  1. len=8 0x12, then len=8 0x34, byte_ready=1 -> bytes 0x12,0x34.
//     byte_valid 1 cycle after each extract.
//  2. len=4 0xA, then len=4 0x5 -> single byte 0xA5; fifo_level peaks at 1.
//  3. len=8 0xFF, then len=8 0x01 -> bytes 0xFF,0x00,0x01.
//     bits_ready is low during the STUFF cycle.
//  4. len=3 0b101, then flush -> byte 0xBF, then flush_done pulse.
//     With JPEG_EOI_EN: 0xBF,0xFF,0xD9, then flush_done.
//     len=4 0xF + flush -> 0xFF,0x00.
//  5. byte_ready=0, stream 20 len=8 chunks 0x00..0x13 -> bits_ready drops at fifo_level>=FIFO_DEPTH-1.
//     Release byte_ready -> all 20 bytes in order, none lost.
//  6. reset_n low for 1 cycle after 11 bits are buffered and FIFO level is 3 -> next cycle byte_valid=0, fifo_level=0.
//     A following len=8 0x55 yields exactly 0x55.

Source files
------------

// File: rtl/jpeg_bitstream_packer.sv
`default_nettype none
// ============================================================================
// jpeg_bitstream_packer : packs Huffman code chunks MSB-first into bytes with
// 0xFF stuffing, 1-padding on flush and an output byte FIFO. Option JPEG_EOI_EN.
// Rev 1.0
// ============================================================================
module jpeg_bitstream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       bits_in,
  input  logic [3:0]       bits_len,
  input  logic             bits_valid,
  output logic             bits_ready,
  input  logic             flush,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             flush_done,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    STUFF = 3'd1,
    FLUSH = 3'd2,
    PAD   = 3'd3,
`ifdef JPEG_EOI_EN
    EOI1  = 3'd4,
    EOI2  = 3'd5,
`endif
    DONE  = 3'd6
  } state_t;

`ifdef JPEG_EOI_EN
  localparam state_t END_ST = EOI1;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t           state;
  state_t           ret_state;
  logic [15:0]      acc;
  logic [3:0]       cnt;
  logic             flush_pending;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nx;
  logic [LVL_W-1:0] level;
  logic [7:0]       head;

  logic [LVL_W-1:0] free;
  logic             room1;
  logic             room2;
  logic             extract;
  logic             accept;
  logic [3:0]       len;
  logic [3:0]       cnt_x;
  logic [15:0]      acc_x;
  logic [7:0]       chunk;
  logic [4:0]       shamt;
  logic [15:0]      placed;
  logic [15:0]      acc_in;
  logic [3:0]       cnt_in;
  logic [7:0]       pad_byte;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             rd_en;

  always_comb begin
    free     = DEPTH_L - level;
    room2    = (free >= LVL_W'(2));
    room1    = (free != '0);
    extract  = ((state == RUN) || (state == FLUSH)) && cnt[3] && room2;
    len      = bits_len[3] ? 4'd8 : bits_len;
    cnt_x    = extract ? (cnt - 4'd8) : cnt;
    acc_x    = extract ? {acc[7:0], 8'h00} : acc;
    bits_ready = reset_n && (state == RUN) && !flush_pending && room2
                 && (!cnt[3] || extract);
    accept   = bits_valid && bits_ready;
    // Mask off bits above len, then left-justify right behind the kept bits.
    chunk    = bits_in & (8'hFF >> (4'd8 - len));
    shamt    = 5'd16 - {1'b0, len} - {1'b0, cnt_x};
    placed   = {8'h00, chunk} << shamt;
    acc_in   = accept ? (acc_x | placed) : acc_x;
    cnt_in   = accept ? (cnt_x + len) : cnt_x;
    pad_byte = acc[15:8] | (8'hFF >> cnt[2:0]);

    wr_en   = 1'b0;
    wr_data = acc[15:8];
    case (state)
      RUN, FLUSH: begin
        wr_en   = extract;
        wr_data = acc[15:8];
      end
      STUFF: begin
        wr_en   = room1;
        wr_data = 8'h00;
      end
      PAD: begin
        wr_en   = room2;
        wr_data = pad_byte;
      end
`ifdef JPEG_EOI_EN
      EOI1: begin
        wr_en   = room1;
        wr_data = 8'hFF;
      end
      EOI2: begin
        wr_en   = room1;
        wr_data = 8'hD9;
      end
`endif
      default: begin
        wr_en   = 1'b0;
        wr_data = acc[15:8];
      end
    endcase

    rd_en     = byte_valid && byte_ready;
    rd_ptr_nx = rd_ptr + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RUN;
      ret_state     <= RUN;
      acc           <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (flush && (state != RUN)) flush_pending <= 1'b1;
      case (state)
        RUN: begin
          acc <= acc_in;
          cnt <= cnt_in;
          if (extract && (acc[15:8] == 8'hFF)) begin
            state         <= STUFF;
            ret_state     <= RUN;
            flush_pending <= flush_pending | flush;
          end else if (flush || flush_pending) begin
            state         <= FLUSH;
            flush_pending <= 1'b0;
          end
        end
        FLUSH: begin
          if (extract) begin
            acc <= acc_x;
            cnt <= cnt_x;
            if (acc[15:8] == 8'hFF) begin
              state     <= STUFF;
              ret_state <= FLUSH;
            end
          end else if (!cnt[3]) begin
            if (cnt != 4'd0) begin
              state <= PAD;
            end else begin
              state      <= END_ST;
              flush_done <= (END_ST == DONE);
            end
          end
        end
        PAD: begin
          if (room2) begin
            acc <= '0;
            cnt <= '0;
            if (pad_byte == 8'hFF) begin
              state     <= STUFF;
              ret_state <= END_ST;
            end else begin
              state      <= END_ST;
              flush_done <= (END_ST == DONE);
            end
          end
        end
        STUFF: begin
          if (room1) begin
            state      <= ret_state;
            flush_done <= (ret_state == DONE);
          end
        end
`ifdef JPEG_EOI_EN
        EOI1: begin
          if (room1) state <= EOI2;
        end
        EOI2: begin
          if (room1) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
`endif
        DONE: begin
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // head mirrors mem[rd_ptr] one cycle after any push, so byte_out is a flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr_nx;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && ((level == '0) || (rd_en && (level == LVL_W'(1))))) begin
        head <= wr_data;
      end else if (rd_en && (level > LVL_W'(1))) begin
        head <= mem[rd_ptr_nx];
      end
    end
  end

  assign byte_out   = head;
  assign byte_valid = (level != '0);
  assign fifo_level = level;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_bitstream_packer.sv
`default_nettype none
// Directed self-checking bench for jpeg_bitstream_packer (honours JPEG_EOI_EN).
module tb_jpeg_bitstream_packer;

  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = 5;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [7:0]       bits_in;
  logic [3:0]       bits_len;
  logic             bits_valid;
  logic             bits_ready;
  logic             flush;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             flush_done;
  logic [LVL_W-1:0] fifo_level;

  always #5 clock = ~clock;

  jpeg_bitstream_packer #(.FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bits_in    (bits_in),
    .bits_len   (bits_len),
    .bits_valid (bits_valid),
    .bits_ready (bits_ready),
    .flush      (flush),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .flush_done (flush_done),
    .fifo_level (fifo_level)
  );

  int         checks = 0;
  int         errors = 0;
  int         peak   = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  // Inputs move at posedge+2, so a negedge sample sees what the next edge takes.
  always @(negedge clock) begin
    if (reset_n && byte_valid && byte_ready) got.push_back(byte_out);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [3:0] len, input logic [7:0] data);
    int n = 0;
    bits_len   = len;
    bits_in    = data;
    bits_valid = 1'b1;
    @(negedge clock);
    while (!bits_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("send_ready", bits_ready, 1'b1);
    tick();
    bits_valid = 1'b0;
  endtask

  task automatic expect_bytes(input string tag);
    int n = 0;
    while (got.size() < exp_q.size() && n < 300) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    check({tag, "_count"}, got.size(), exp_q.size());
    foreach (exp_q[i]) check(tag, (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, exp_q[i]);
    got.delete();
    exp_q.delete();
    tick();
  endtask

  task automatic wait_flush_done(input string tag);
    int n = 0;
    @(negedge clock);
    while (!flush_done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(tag, flush_done, 1'b1);
    @(negedge clock);
    check({tag, "_pulse"}, flush_done, 1'b0);
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    bits_in    = 8'h00;
    bits_len   = 4'd0;
    bits_valid = 1'b0;
    flush      = 1'b0;
    byte_ready = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_bits_ready", bits_ready, 1'b0);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_fifo_level", fifo_level, '0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_byte_out",   byte_out,   8'h00);
    tick();
    reset_n    = 1'b1;
    byte_ready = 1'b1;
    tick();

    // Two whole bytes; head appears one cycle after its extract.
    send(4'd8, 8'h12);
    check("t1_not_yet_valid", byte_valid, 1'b0);
    send(4'd8, 8'h34);
    @(negedge clock);
    check("t1_valid", byte_valid, 1'b1);
    check("t1_head",  byte_out,   8'h12);
    exp_q = '{8'h12, 8'h34};
    expect_bytes("t1_bytes");

    // Two nibbles merge into one byte.
    peak = 0;
    send(4'd4, 8'h0A);
    send(4'd4, 8'h05);
    exp_q = '{8'hA5};
    expect_bytes("t2_bytes");
    check("t2_peak", peak, 1);

    // 0xFF gets a stuffed 0x00; no accept during the stuff cycle.
    send(4'd8, 8'hFF);
    send(4'd8, 8'h01);
    @(negedge clock);
    check("t3_ready_in_stuff", bits_ready, 1'b0);
    exp_q = '{8'hFF, 8'h00, 8'h01};
    expect_bytes("t3_bytes");

    // Three bits then flush: padded with ones.
    send(4'd3, 8'h05);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_flush_done("t4_done");
`ifdef JPEG_EOI_EN
    exp_q = '{8'hBF, 8'hFF, 8'hD9};
`else
    exp_q = '{8'hBF};
`endif
    expect_bytes("t4_bytes");

    // Chunk and flush together: chunk first, padded 0xFF is stuffed.
    bits_valid = 1'b1;
    bits_len   = 4'd4;
    bits_in    = 8'h0F;
    flush      = 1'b1;
    @(negedge clock);
    check("t4b_accept", bits_ready, 1'b1);
    tick();
    bits_valid = 1'b0;
    flush      = 1'b0;
    wait_flush_done("t4b_done");
`ifdef JPEG_EOI_EN
    exp_q = '{8'hFF, 8'h00, 8'hFF, 8'hD9};
`else
    exp_q = '{8'hFF, 8'h00};
`endif
    expect_bytes("t4b_bytes");

    // Backpressure: fill, stall, release; all 20 bytes in order.
    byte_ready = 1'b0;
    tick();
    fork
      begin
        for (int i = 0; i < 20; i++) send(4'd8, 8'(i));
      end
      begin
        repeat (30) @(negedge clock);
        check("t5_stall_ready", bits_ready, 1'b0);
        check("t5_stall_level", fifo_level, LVL_W'(FIFO_DEPTH - 1));
        @(posedge clock);
        #2;
        byte_ready = 1'b1;
      end
    join
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
    expect_bytes("t5_bytes");

    // Reset mid-stream: level 3 with 11 bits buffered is discarded.
    byte_ready = 1'b0;
    tick();
    send(4'd8, 8'h01);
    send(4'd8, 8'h02);
    send(4'd8, 8'h03);
    send(4'd3, 8'h05);
    send(4'd8, 8'hAA);
    check("t6_pre_level", fifo_level, LVL_W'(3));
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", byte_valid, 1'b0);
    check("t6_rst_level", fifo_level, '0);
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    check("t6_post_valid", byte_valid, 1'b0);
    check("t6_post_level", fifo_level, '0);
    tick();
    got.delete();
    byte_ready = 1'b1;
    send(4'd8, 8'h55);
    exp_q = '{8'h55};
    expect_bytes("t6_bytes");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
